// File: rtl/uart_transceiver.sv
// UART transceiver: 8N1 transmitter and receiver at 16x oversampling,
// with a small receive FIFO and sticky overrun / framing-error flags.
module uart_transceiver #(
    parameter int CLK_DIV    = 27,
    parameter int FIFO_DEPTH = 4
) (
    input  logic       MCLK_IN,
    input  logic       RESET_IN,
    input  logic       SEND_TRIGGER_IN,
    input  logic [7:0] SEND_BYTE_IN,
    input  logic       RECEIVE_CAPTURE_IN,
    input  logic       RXD_IN,
    output logic       TXD,
    output logic       SEND_BUSY,
    output logic       RECEIVED,
    output logic [7:0] RECEIVE_BYTE,
    output logic       OVERRUN,
    output logic       FRAME_ERROR
);

    localparam int             PW        = $clog2(FIFO_DEPTH);
    localparam logic [9:0]     DIV_LAST  = 10'(CLK_DIV - 1);
    localparam logic [PW:0]    DEPTH_CNT = (PW + 1)'(FIFO_DEPTH);
    localparam logic [PW:0]    CNT_ONE   = (PW + 1)'(1);
    localparam logic [PW-1:0]  PTR_ONE   = PW'(1);

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

    logic trigPrev_q, capPrev_q;
    logic trigRise, capFall;

    state_t     txState_q, txState_d;
    logic [9:0] txDiv_q, txDiv_d;
    logic [3:0] txTick_q, txTick_d;
    logic [2:0] txIdx_q, txIdx_d;
    logic [7:0] txByte_q, txByte_d;
    logic       txd_q, txd_d;
    logic       busy_q, busy_d;
    logic       txBitEnd;

    logic       rxS1_q, rxS2_q;
    state_t     rxState_q, rxState_d;
    logic [9:0] rxDiv_q, rxDiv_d;
    logic [3:0] rxTick_q, rxTick_d;
    logic [2:0] rxIdx_q, rxIdx_d;
    logic [7:0] rxShift_q, rxShift_d;
    logic       breakWait_q, breakWait_d;
    logic       rxTickPulse, rxPush, rxFerrSet;

    logic [7:0]    fifoMem_q [FIFO_DEPTH];
    logic [PW-1:0] wrPtr_q, wrPtr_d, rdPtr_q, rdPtr_d;
    logic [PW:0]   count_q, count_d;
    logic          received_q, received_d;
    logic [7:0]    head_q, head_d;
    logic          overrun_q, overrun_d;
    logic          ferr_q, ferr_d;
    logic          popOk, doPush, ovrSet;

    assign trigRise = SEND_TRIGGER_IN & ~trigPrev_q;
    assign capFall  = capPrev_q & ~RECEIVE_CAPTURE_IN;

    // Remember last cycle's strobe levels for edge detection and double-flop RXD.
    always_ff @(posedge MCLK_IN) begin
        if (RESET_IN) begin
            trigPrev_q <= 1'b0;
            capPrev_q  <= 1'b0;
            rxS1_q     <= 1'b1;
            rxS2_q     <= 1'b1;
        end else begin
            trigPrev_q <= SEND_TRIGGER_IN;
            capPrev_q  <= RECEIVE_CAPTURE_IN;
            rxS1_q     <= RXD_IN;
            rxS2_q     <= rxS1_q;
        end
    end

    // Transmitter next state: one bit lasts 16 ticks of CLK_DIV cycles each.
    always_comb begin
        txState_d = txState_q;
        txDiv_d   = txDiv_q;
        txTick_d  = txTick_q;
        txIdx_d   = txIdx_q;
        txByte_d  = txByte_q;
        txBitEnd  = (txDiv_q == DIV_LAST) && (txTick_q == 4'hF);
        if (txState_q != S_IDLE) begin
            if (txDiv_q == DIV_LAST) begin
                txDiv_d  = 10'd0;
                txTick_d = txTick_q + 4'd1;
            end else begin
                txDiv_d = txDiv_q + 10'd1;
            end
        end
        case (txState_q)
            S_IDLE: begin
                if (trigRise) begin
                    txByte_d  = SEND_BYTE_IN;
                    txState_d = S_START;
                    txDiv_d   = 10'd0;
                    txTick_d  = 4'd0;
                    txIdx_d   = 3'd0;
                end
            end
            S_START: begin
                if (txBitEnd) begin
                    txState_d = S_DATA;
                    txIdx_d   = 3'd0;
                end
            end
            S_DATA: begin
                if (txBitEnd) begin
                    txIdx_d = txIdx_q + 3'd1;
                    if (txIdx_q == 3'd7) begin
                        txState_d = S_STOP;
                    end
                end
            end
            default: begin
                if (txBitEnd) begin
                    txState_d = S_IDLE;
                end
            end
        endcase
        case (txState_d)
            S_START: txd_d = 1'b0;
            S_DATA:  txd_d = txByte_d[txIdx_d];
            default: txd_d = 1'b1;
        endcase
        busy_d = (txState_d != S_IDLE);
    end

    // Transmitter registers; TXD and busy are registered so they switch together.
    always_ff @(posedge MCLK_IN) begin
        if (RESET_IN) begin
            txState_q <= S_IDLE;
            txDiv_q   <= 10'd0;
            txTick_q  <= 4'd0;
            txIdx_q   <= 3'd0;
            txByte_q  <= 8'h00;
            txd_q     <= 1'b1;
            busy_q    <= 1'b0;
        end else begin
            txState_q <= txState_d;
            txDiv_q   <= txDiv_d;
            txTick_q  <= txTick_d;
            txIdx_q   <= txIdx_d;
            txByte_q  <= txByte_d;
            txd_q     <= txd_d;
            busy_q    <= busy_d;
        end
    end

    // Receiver next state: mid-bit sampling, early return to idle after a good stop bit.
    always_comb begin
        rxState_d   = rxState_q;
        rxDiv_d     = rxDiv_q;
        rxTick_d    = rxTick_q;
        rxIdx_d     = rxIdx_q;
        rxShift_d   = rxShift_q;
        breakWait_d = breakWait_q;
        rxPush      = 1'b0;
        rxFerrSet   = 1'b0;
        rxTickPulse = (rxDiv_q == DIV_LAST);
        if (rxState_q != S_IDLE) begin
            if (rxTickPulse) begin
                rxDiv_d  = 10'd0;
                rxTick_d = rxTick_q + 4'd1;
            end else begin
                rxDiv_d = rxDiv_q + 10'd1;
            end
        end
        case (rxState_q)
            S_IDLE: begin
                if (rxS2_q) begin
                    breakWait_d = 1'b0;
                end else if (!breakWait_q) begin
                    rxState_d = S_START;
                    rxDiv_d   = 10'd0;
                    rxTick_d  = 4'd0;
                end
            end
            S_START: begin
                if (rxTickPulse && rxTick_q == 4'd7) begin
                    if (rxS2_q) begin
                        rxState_d = S_IDLE;
                    end else begin
                        rxState_d = S_DATA;
                        rxTick_d  = 4'd0;
                        rxIdx_d   = 3'd0;
                    end
                end
            end
            S_DATA: begin
                if (rxTickPulse && rxTick_q == 4'hF) begin
                    rxShift_d = {rxS2_q, rxShift_q[7:1]};
                    rxIdx_d   = rxIdx_q + 3'd1;
                    if (rxIdx_q == 3'd7) begin
                        rxState_d = S_STOP;
                    end
                end
            end
            default: begin
                if (rxTickPulse && rxTick_q == 4'hF) begin
                    rxState_d = S_IDLE;
                    if (rxS2_q) begin
                        rxPush = 1'b1;
                    end else begin
                        rxFerrSet   = 1'b1;
                        breakWait_d = 1'b1;
                    end
                end
            end
        endcase
    end

    // Receiver registers.
    always_ff @(posedge MCLK_IN) begin
        if (RESET_IN) begin
            rxState_q   <= S_IDLE;
            rxDiv_q     <= 10'd0;
            rxTick_q    <= 4'd0;
            rxIdx_q     <= 3'd0;
            rxShift_q   <= 8'h00;
            breakWait_q <= 1'b0;
        end else begin
            rxState_q   <= rxState_d;
            rxDiv_q     <= rxDiv_d;
            rxTick_q    <= rxTick_d;
            rxIdx_q     <= rxIdx_d;
            rxShift_q   <= rxShift_d;
            breakWait_q <= breakWait_d;
        end
    end

    // FIFO bookkeeping, sticky flags and the registered head/status presented to the bus side.
    always_comb begin
        popOk  = capFall && (count_q != '0);
        doPush = rxPush && ((count_q != DEPTH_CNT) || popOk);
        ovrSet = rxPush && (count_q == DEPTH_CNT) && !popOk;
        wrPtr_d = doPush ? wrPtr_q + PTR_ONE : wrPtr_q;
        rdPtr_d = popOk ? rdPtr_q + PTR_ONE : rdPtr_q;
        count_d = count_q;
        if (doPush && !popOk) begin
            count_d = count_q + CNT_ONE;
        end else if (popOk && !doPush) begin
            count_d = count_q - CNT_ONE;
        end
        overrun_d = ovrSet ? 1'b1 : (popOk ? 1'b0 : overrun_q);
        ferr_d    = rxFerrSet ? 1'b1 : (popOk ? 1'b0 : ferr_q);
        received_d = (count_d != '0);
        if (count_d == '0) begin
            head_d = 8'h00;
        end else if (doPush && (wrPtr_q == rdPtr_d)) begin
            head_d = rxShift_q;
        end else begin
            head_d = fifoMem_q[rdPtr_d];
        end
    end

    // FIFO pointers, count, flags and output registers.
    always_ff @(posedge MCLK_IN) begin
        if (RESET_IN) begin
            wrPtr_q    <= '0;
            rdPtr_q    <= '0;
            count_q    <= '0;
            overrun_q  <= 1'b0;
            ferr_q     <= 1'b0;
            received_q <= 1'b0;
            head_q     <= 8'h00;
        end else begin
            wrPtr_q    <= wrPtr_d;
            rdPtr_q    <= rdPtr_d;
            count_q    <= count_d;
            overrun_q  <= overrun_d;
            ferr_q     <= ferr_d;
            received_q <= received_d;
            head_q     <= head_d;
        end
    end

    // FIFO storage; contents need no reset since the count gates every read.
    always_ff @(posedge MCLK_IN) begin
        if (!RESET_IN && doPush) begin
            fifoMem_q[wrPtr_q] <= rxShift_q;
        end
    end

    assign TXD          = txd_q;
    assign SEND_BUSY    = busy_q;
    assign RECEIVED     = received_q;
    assign RECEIVE_BYTE = head_q;
    assign OVERRUN      = overrun_q;
    assign FRAME_ERROR  = ferr_q;

endmodule

// File: tb/tb_uart_transceiver.sv
// Testbench for uart_transceiver: fixed vector table, directed corner cases
// and randomized frames checked against a queue-based FIFO/flag model.
module tb_uart_transceiver;

    localparam int CLK_DIV    = 4;
    localparam int FIFO_DEPTH = 4;
    localparam int BIT        = 16 * CLK_DIV;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       trig = 1'b0;
    logic [7:0] sendByte = 8'h00;
    logic       cap = 1'b0;
    logic       rxd = 1'b1;
    logic       txd, sendBusy, received, overrun, frameError;
    logic [7:0] receiveByte;

    int checks = 0;
    int failures = 0;

    logic [7:0] fifoQ[$];
    bit         modelOvr = 1'b0;
    bit         modelFerr = 1'b0;

    typedef struct {
        bit         isPop;
        logic [7:0] data;
        bit         goodStop;
        bit         expRec;
        logic [7:0] expByte;
        bit         expOvr;
        bit         expFerr;
    } vec_t;

    vec_t vecs[13];

    uart_transceiver #(.CLK_DIV(CLK_DIV), .FIFO_DEPTH(FIFO_DEPTH)) dut (
        .MCLK_IN(clk),
        .RESET_IN(reset),
        .SEND_TRIGGER_IN(trig),
        .SEND_BYTE_IN(sendByte),
        .RECEIVE_CAPTURE_IN(cap),
        .RXD_IN(rxd),
        .TXD(txd),
        .SEND_BUSY(sendBusy),
        .RECEIVED(received),
        .RECEIVE_BYTE(receiveByte),
        .OVERRUN(overrun),
        .FRAME_ERROR(frameError)
    );

    always #5 clk = ~clk;

    // Compare one observed value against the bench's own expectation.
    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: actual=%0h expected=%0h", name, actual, expected);
        end
    endtask

    // Serial level of a frame at bit position idx: start, 8 data bits LSB first, stop.
    function automatic logic frameBit(input logic [7:0] b, input int idx);
        if (idx == 0) return 1'b0;
        if (idx <= 8) return b[idx - 1];
        return 1'b1;
    endfunction

    // Check receive-side outputs against the reference FIFO model.
    task automatic checkRxState(input string tag);
        logic [7:0] head;
        head = (fifoQ.size() != 0) ? fifoQ[0] : 8'h00;
        checkOutput({tag, ".received"}, received, (fifoQ.size() != 0));
        checkOutput({tag, ".byte"}, receiveByte, head);
        checkOutput({tag, ".overrun"}, overrun, modelOvr);
        checkOutput({tag, ".frameError"}, frameError, modelFerr);
    endtask

    // Drive one serial frame on RXD and update the model with its effect.
    task automatic applyStimulus(input logic [7:0] b, input bit goodStop);
        for (int i = 0; i < 10; i++) begin
            rxd = (i == 9) ? goodStop : frameBit(b, i);
            repeat (BIT) @(negedge clk);
        end
        rxd = 1'b1;
        repeat (8) @(negedge clk);
        if (goodStop) begin
            if (fifoQ.size() < FIFO_DEPTH) fifoQ.push_back(b);
            else modelOvr = 1'b1;
        end else begin
            modelFerr = 1'b1;
        end
    endtask

    // One CPU read: head must stay stable during the strobe, pop on its falling edge.
    task automatic popCapture(input int len);
        logic [7:0] head;
        int moved;
        head = (fifoQ.size() != 0) ? fifoQ[0] : 8'h00;
        moved = 0;
        cap = 1'b1;
        for (int i = 0; i < len; i++) begin
            @(negedge clk);
            if (receiveByte !== head) moved++;
        end
        cap = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("captureHold", moved, 0);
        if (fifoQ.size() != 0) begin
            void'(fifoQ.pop_front());
            modelOvr = 1'b0;
            modelFerr = 1'b0;
        end
    endtask

    // Send a byte and check every cycle of the frame; optionally retrigger mid-frame.
    task automatic runTx(input logic [7:0] b, input bit intrude);
        int since, busyCnt, ghost;
        bit found;
        int bad[10];
        sendByte = b;
        trig = 1'b1;
        since = 0;
        found = 1'b0;
        for (int w = 0; w < 20 && !found; w++) begin
            @(negedge clk);
            since++;
            if (since == 6) trig = 1'b0;
            if (txd === 1'b0) found = 1'b1;
        end
        trig = (since < 6) ? trig : 1'b0;
        checkOutput("txStartSeen", found, 1);
        if (found) begin
            for (int i = 0; i < 10; i++) bad[i] = 0;
            busyCnt = 0;
            for (int k = 0; k < 10 * BIT; k++) begin
                if (txd !== frameBit(b, k / BIT)) bad[k / BIT]++;
                if (sendBusy === 1'b1) busyCnt++;
                @(negedge clk);
                since++;
                if (since == 6) trig = 1'b0;
                if (intrude && k == 300) begin
                    sendByte = 8'h3C;
                    trig = 1'b1;
                end
                if (intrude && k == 306) trig = 1'b0;
            end
            for (int i = 0; i < 10; i++) checkOutput($sformatf("txBit%0d", i), bad[i], 0);
            checkOutput("busyLength", busyCnt, 10 * BIT);
            checkOutput("busyEnd", sendBusy, 1'b0);
            checkOutput("txdEnd", txd, 1'b1);
        end
        trig = 1'b0;
        ghost = 0;
        repeat (300) begin
            @(negedge clk);
            if (txd !== 1'b1 || sendBusy !== 1'b0) ghost++;
        end
        checkOutput("txNoSecondFrame", ghost, 0);
    endtask

    initial begin
        vecs[0]  = '{1'b0, 8'h01, 1'b1, 1'b1, 8'h01, 1'b0, 1'b0};
        vecs[1]  = '{1'b0, 8'h02, 1'b1, 1'b1, 8'h01, 1'b0, 1'b0};
        vecs[2]  = '{1'b0, 8'h03, 1'b1, 1'b1, 8'h01, 1'b0, 1'b0};
        vecs[3]  = '{1'b0, 8'h04, 1'b1, 1'b1, 8'h01, 1'b0, 1'b0};
        vecs[4]  = '{1'b0, 8'h05, 1'b1, 1'b1, 8'h01, 1'b1, 1'b0};
        vecs[5]  = '{1'b1, 8'h00, 1'b0, 1'b1, 8'h02, 1'b0, 1'b0};
        vecs[6]  = '{1'b1, 8'h00, 1'b0, 1'b1, 8'h03, 1'b0, 1'b0};
        vecs[7]  = '{1'b1, 8'h00, 1'b0, 1'b1, 8'h04, 1'b0, 1'b0};
        vecs[8]  = '{1'b1, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0};
        vecs[9]  = '{1'b1, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0};
        vecs[10] = '{1'b0, 8'hFF, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1};
        vecs[11] = '{1'b0, 8'h5A, 1'b1, 1'b1, 8'h5A, 1'b0, 1'b1};
        vecs[12] = '{1'b1, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0};

        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        checkOutput("resetTxd", txd, 1'b1);
        checkOutput("resetBusy", sendBusy, 1'b0);
        checkRxState("reset");

        $display("[TB] transmit 8'hA5");
        runTx(8'hA5, 1'b0);
        $display("[TB] transmit 8'hA5 with retrigger while busy");
        runTx(8'hA5, 1'b1);

        $display("[TB] receive 8'h5A and read it");
        applyStimulus(8'h5A, 1'b1);
        checkRxState("rx5A");
        popCapture(4);
        checkRxState("rx5Apopped");

        $display("[TB] false start pulse");
        rxd = 1'b0;
        repeat (20) @(negedge clk);
        rxd = 1'b1;
        repeat (100) @(negedge clk);
        checkRxState("falseStart");

        $display("[TB] vector table");
        for (int i = 0; i < 13; i++) begin
            if (vecs[i].isPop) popCapture(4);
            else applyStimulus(vecs[i].data, vecs[i].goodStop);
            checkOutput($sformatf("vec%0d.received", i), received, vecs[i].expRec);
            checkOutput($sformatf("vec%0d.byte", i), receiveByte, vecs[i].expByte);
            checkOutput($sformatf("vec%0d.overrun", i), overrun, vecs[i].expOvr);
            checkOutput($sformatf("vec%0d.frameError", i), frameError, vecs[i].expFerr);
        end

        $display("[TB] randomized traffic");
        for (int i = 0; i < 12; i++) begin
            if ($urandom_range(0, 2) == 0) popCapture($urandom_range(1, 6));
            else applyStimulus(8'($urandom), ($urandom_range(0, 5) != 0));
            checkRxState($sformatf("rand%0d", i));
        end
        runTx(8'($urandom), 1'b0);

        $display("[TB] reset mid-frame");
        applyStimulus(8'h42, 1'b1);
        sendByte = 8'h77;
        trig = 1'b1;
        for (int c = 0; c < 200; c++) begin
            rxd = frameBit(8'h33, c / BIT);
            if (c == 6) trig = 1'b0;
            @(negedge clk);
        end
        reset = 1'b1;
        rxd = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        fifoQ.delete();
        modelOvr = 1'b0;
        modelFerr = 1'b0;
        checkOutput("midResetTxd", txd, 1'b1);
        checkOutput("midResetBusy", sendBusy, 1'b0);
        checkRxState("midReset");
        begin
            int ghost;
            ghost = 0;
            repeat (700) begin
                @(negedge clk);
                if (txd !== 1'b1 || sendBusy !== 1'b0 || received !== 1'b0) ghost++;
            end
            checkOutput("afterResetQuiet", ghost, 0);
        end
        applyStimulus(8'h81, 1'b1);
        checkRxState("rx81");
        popCapture(4);
        checkRxState("rx81popped");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
